// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) responder, oversampled with the fabric clock.
// Detects START/STOP, matches a fixed 7-bit address, hands written bytes to
// user logic and requests bytes from it for reads. SDA is open-drain only
// (sda_oe=1 pulls low); SCL is never driven, so there is no clock stretching.
// Ports:
//   clk        fabric clock, at least 8x the SCL rate
//   reset      asynchronous, active-high
//   scl_in     raw SCL pin level
//   sda_in     raw SDA pin level
//   sda_oe     1 = pull SDA low, 0 = release
//   rx_data    last byte written by the controller
//   rx_valid   one-clk strobe, rx_data valid
//   rx_ready   sampled with each write byte; 0 = NACK that byte
//   tx_data    byte to return on a read
//   tx_req     one-clk strobe requesting the next tx_data
//   addressed  high while this target is selected
//   start_det  one-clk pulse on START or repeated START
//   stop_det   one-clk pulse on STOP
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h42
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  output logic       tx_req,
  output logic       addressed,
  output logic       start_det,
  output logic       stop_det
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    WRITE,
    WRITE_ACK,
    READ,
    READ_ACK,
    WAIT_STOP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       rw_q, rw_d;
  logic       phase_q, phase_d;
  logic       sda_oe_q, sda_oe_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       tx_req_q, tx_req_d;
  logic       addressed_q, addressed_d;
  logic       start_q, start_d;
  logic       stop_q, stop_d;

  logic scl_rise, scl_fall, sda_rise, sda_fall;
  logic start_cond, stop_cond, sda_bit;

  // Stages 0/1 synchronise, stage 2 is the delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], scl_in};
      sda_sync_q <= {sda_sync_q[1:0], sda_in};
    end
  end

  assign scl_rise   =  scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall   = ~scl_sync_q[1] &  scl_sync_q[2];
  assign sda_rise   =  sda_sync_q[1] & ~sda_sync_q[2];
  assign sda_fall   = ~sda_sync_q[1] &  sda_sync_q[2];
  assign sda_bit    =  sda_sync_q[1];
  // SCL must be high in both compared stages so an SDA edge racing an SCL
  // edge is never mistaken for START/STOP.
  assign start_cond = sda_fall & scl_sync_q[1] & scl_sync_q[2];
  assign stop_cond  = sda_rise & scl_sync_q[1] & scl_sync_q[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      phase_q     <= 1'b0;
      sda_oe_q    <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      tx_req_q    <= 1'b0;
      addressed_q <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      phase_q     <= phase_d;
      sda_oe_q    <= sda_oe_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      tx_req_q    <= tx_req_d;
      addressed_q <= addressed_d;
      start_q     <= start_d;
      stop_q      <= stop_d;
    end
  end

  // phase_q splits the two-fall ACK slots: 0 = waiting for the fall that
  // starts the slot, 1 = slot active, waiting for the fall that ends it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    phase_d     = phase_q;
    sda_oe_d    = sda_oe_q;
    rx_data_d   = rx_data_q;
    addressed_d = addressed_q;
    rx_valid_d  = 1'b0;
    tx_req_d    = 1'b0;
    start_d     = 1'b0;
    stop_d      = 1'b0;

    if (start_cond) begin
      start_d     = 1'b1;
      cnt_d       = 3'd7;
      phase_d     = 1'b0;
      state_d     = ADDR;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else if (stop_cond) begin
      stop_d      = 1'b1;
      state_d     = IDLE;
      sda_oe_d    = 1'b0;
      addressed_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: ;
        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_bit};
            if (cnt_q == 3'd0) begin
              rw_d    = sda_bit;
              phase_d = 1'b0;
              state_d = (shift_q[6:0] == ADDRESS) ? ADDR_ACK : WAIT_STOP;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_rise && phase_q && rw_q) tx_req_d = 1'b1;
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d    = 1'b1;
              addressed_d = 1'b1;
              phase_d     = 1'b1;
            end else begin
              cnt_d = 3'd7;
              if (rw_q) begin
                shift_d  = tx_data;
                sda_oe_d = ~tx_data[7];
                state_d  = READ;
              end else begin
                sda_oe_d = 1'b0;
                state_d  = WRITE;
              end
            end
          end
        end
        WRITE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_bit};
            if (cnt_q == 3'd0) begin
              rx_data_d  = {shift_q[6:0], sda_bit};
              rx_valid_d = 1'b1;
              phase_d    = 1'b0;
              state_d    = rx_ready ? WRITE_ACK : WAIT_STOP;
            end else begin
              cnt_d = cnt_q - 3'd1;
            end
          end
        end
        WRITE_ACK: begin
          if (scl_fall) begin
            if (!phase_q) begin
              sda_oe_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              sda_oe_d = 1'b0;
              cnt_d    = 3'd7;
              state_d  = WRITE;
            end
          end
        end
        READ: begin
          // cnt_q is the index of the bit currently on the bus.
          if (scl_fall) begin
            if (cnt_q == 3'd0) begin
              sda_oe_d = 1'b0;
              phase_d  = 1'b0;
              state_d  = READ_ACK;
            end else begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
              cnt_d    = cnt_q - 3'd1;
            end
          end
        end
        READ_ACK: begin
          if (scl_rise && !phase_q) begin
            if (!sda_bit) begin
              tx_req_d = 1'b1;
              phase_d  = 1'b1;
            end else begin
              state_d = WAIT_STOP;
            end
          end else if (scl_fall && phase_q) begin
            shift_d  = tx_data;
            sda_oe_d = ~tx_data[7];
            cnt_d    = 3'd7;
            state_d  = READ;
          end
        end
        WAIT_STOP: begin
          sda_oe_d    = 1'b0;
          addressed_d = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign sda_oe    = sda_oe_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign tx_req    = tx_req_q;
  assign addressed = addressed_q;
  assign start_det = start_q;
  assign stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_target.sv
// tb_i2c_target: bit-banged I2C controller model driving i2c_target over an
// open-drain SDA line, with scoreboard queues for written and read bytes.
module tb_i2c_target;

  localparam int Q = 80;  // quarter SCL period, 8 fabric clocks

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       sda_m_low = 1'b0;
  logic       sda_line;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_req;
  logic       addressed;
  logic       start_det;
  logic       stop_det;

  assign sda_line = ~(sda_m_low | sda_oe);

  i2c_target #(.ADDRESS(7'h42)) dut (
    .clk       (clk),
    .reset     (reset),
    .scl_in    (scl),
    .sda_in    (sda_line),
    .sda_oe    (sda_oe),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .tx_data   (tx_data),
    .tx_req    (tx_req),
    .addressed (addressed),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0] exp_rx[$];
  logic [7:0] exp_rd[$];
  logic [7:0] tx_src[$];
  int rx_cnt = 0, txreq_cnt = 0, start_cnt = 0, stop_cnt = 0;
  logic oe_seen = 1'b0;

  // Output monitor: pops expected write bytes, answers tx_req from tx_src
  // and records each supplied byte as the next expected read byte.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) begin
        rx_cnt++;
        if (exp_rx.size() > 0) check("rx_data", {24'h0, rx_data}, {24'h0, exp_rx.pop_front()});
      end
      if (tx_req) begin
        txreq_cnt++;
        if (tx_src.size() > 0) begin
          tx_data = tx_src.pop_front();
          exp_rd.push_back(tx_data);
        end
      end
      if (start_det) start_cnt++;
      if (stop_det) stop_cnt++;
      if (sda_oe) oe_seen = 1'b1;
    end
  end

  task automatic clk_bit(input logic drv_low, output logic smp);
    #Q sda_m_low = drv_low;
    #Q scl = 1'b1;
    #Q smp = sda_line;
    #Q scl = 1'b0;
  endtask

  task automatic start_c();
    sda_m_low = 1'b0;
    #Q scl = 1'b1;
    #Q sda_m_low = 1'b1;
    #Q scl = 1'b0;
  endtask

  task automatic stop_c();
    sda_m_low = 1'b1;
    #Q scl = 1'b1;
    #Q sda_m_low = 1'b0;
    #Q;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clk_bit(~b[i], s);
    clk_bit(1'b0, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic m_ack, input string tag);
    logic s;
    logic [7:0] d;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b0, s);
      d[i] = s;
    end
    clk_bit(m_ack, s);
    if (exp_rd.size() > 0) check(tag, {24'h0, d}, {24'h0, exp_rd.pop_front()});
    else check({tag, "_noexp"}, exp_rd.size(), 1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_sda_oe"}, sda_oe, 0);
    check({tag, "_rx_data"}, rx_data, 0);
    check({tag, "_rx_valid"}, rx_valid, 0);
    check({tag, "_tx_req"}, tx_req, 0);
    check({tag, "_addressed"}, addressed, 0);
    check({tag, "_start_det"}, start_det, 0);
    check({tag, "_stop_det"}, stop_det, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic ack;
  int rx0, tx0, st0, sp0;

  initial begin
    repeat (3) @(posedge clk);
    #1 check_reset_vals("rst");
    @(negedge clk) reset = 1'b0;
    #Q;

    // Write 0xA5, 0x3C to 0x42.
    rx0 = rx_cnt; sp0 = stop_cnt;
    start_c();
    send_byte(8'h84, ack);
    check("t1_addr_ack", ack, 1);
    check("t1_addressed", addressed, 1);
    exp_rx.push_back(8'hA5);
    send_byte(8'hA5, ack);
    check("t1_ack_a5", ack, 1);
    exp_rx.push_back(8'h3C);
    send_byte(8'h3C, ack);
    check("t1_ack_3c", ack, 1);
    stop_c();
    #Q;
    check("t1_rx_cnt", rx_cnt - rx0, 2);
    check("t1_stop", stop_cnt - sp0, 1);
    check("t1_addressed_end", addressed, 0);

    // Non-matching address 0x43: no response at all.
    rx0 = rx_cnt; oe_seen = 1'b0;
    start_c();
    send_byte(8'h86, ack);
    check("t2_addr_nack", ack, 0);
    check("t2_addressed", addressed, 0);
    send_byte(8'h55, ack);
    check("t2_data_nack", ack, 0);
    stop_c();
    #Q;
    check("t2_oe_seen", oe_seen, 0);
    check("t2_rx_cnt", rx_cnt - rx0, 0);

    // Read 0x5A (ACK) then 0xC3 (NACK).
    tx0 = txreq_cnt;
    tx_src.push_back(8'h5A);
    tx_src.push_back(8'hC3);
    start_c();
    send_byte(8'h85, ack);
    check("t3_addr_ack", ack, 1);
    read_byte(1'b1, "t3_rd0");
    read_byte(1'b0, "t3_rd1");
    #Q;
    check("t3_oe_after_nack", sda_oe, 0);
    check("t3_addressed_nack", addressed, 0);
    stop_c();
    #Q;
    check("t3_txreq_cnt", txreq_cnt - tx0, 2);

    // Write 0x10, repeated START, read one byte.
    rx0 = rx_cnt; st0 = start_cnt; sp0 = stop_cnt;
    start_c();
    send_byte(8'h84, ack);
    check("t4_waddr_ack", ack, 1);
    exp_rx.push_back(8'h10);
    send_byte(8'h10, ack);
    check("t4_ack_10", ack, 1);
    tx_src.push_back(8'h99);
    start_c();
    send_byte(8'h85, ack);
    check("t4_raddr_ack", ack, 1);
    read_byte(1'b0, "t4_rd");
    check("t4_start_cnt", start_cnt - st0, 2);
    check("t4_no_stop", stop_cnt - sp0, 0);
    stop_c();
    #Q;
    check("t4_rx_cnt", rx_cnt - rx0, 1);

    // rx_ready=0: byte presented but NACKed, following byte ignored.
    rx0 = rx_cnt; rx_ready = 1'b0;
    start_c();
    send_byte(8'h84, ack);
    check("t5_addr_ack", ack, 1);
    exp_rx.push_back(8'h77);
    send_byte(8'h77, ack);
    check("t5_nack_77", ack, 0);
    send_byte(8'h11, ack);
    check("t5_nack_11", ack, 0);
    stop_c();
    #Q;
    check("t5_rx_cnt", rx_cnt - rx0, 1);
    rx_ready = 1'b1;

    // Reset while driving a 0 bit during a read.
    tx_src.push_back(8'h00);
    start_c();
    send_byte(8'h85, ack);
    check("t6_addr_ack", ack, 1);
    #Q;
    check("t6_oe_driving", sda_oe, 1);
    #3 reset = 1'b1;
    #1 check_reset_vals("t6_rst");
    @(negedge clk) reset = 1'b0;
    exp_rd.delete();
    sda_m_low = 1'b0;
    scl = 1'b1;
    #Q;
    rx0 = rx_cnt;
    start_c();
    send_byte(8'h84, ack);
    check("t6_post_addr_ack", ack, 1);
    exp_rx.push_back(8'h5C);
    send_byte(8'h5C, ack);
    check("t6_post_ack", ack, 1);
    stop_c();
    #Q;
    check("t6_rx_cnt", rx_cnt - rx0, 1);
    check("exp_rx_drained", exp_rx.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
